led_request_sequencer: RTL and testbench

- Scheduler that shares the board RGB LED colour controller among 8 pushbutton requesters.
- Edge-detects button presses and latches them as sticky pending requests.
- Picks one pending request round-robin and drives a one-hot select into the downstream LED controller's 8-bit button input. Holds it for a fixed display window, then blanks for a gap.
- Sits between the raw button pins and the LED colour controller.

---
 rtl/led_req_seq_pkg.sv | 21 ++
 rtl/rr_arbiter8.sv | 28 ++
 rtl/led_request_sequencer.sv | 160 ++++++++++++++++
 tb/tb_led_request_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_req_seq_pkg.sv
// Shared types and constants for the LED request sequencer: state encoding,
// requester count and one-hot helper.
package led_req_seq_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_arbiter8.sv
// Combinational 8-way round-robin arbiter: the search starts one past the last
// grant and wraps, so the most recently served requester has lowest priority.
module rr_arbiter8
    import led_req_seq_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = IDX_W'(int'(last) + i);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/led_request_sequencer.sv
// Shares the RGB LED colour controller among 8 buttons: latches presses as
// pending requests and shows one at a time for a hold window plus a blank gap.
// Define LED_REQ_SEQ_DEMO_EN to inject synthetic requests after an idle timeout.
module led_request_sequencer
    import led_req_seq_pkg::*;
#(
    parameter int HOLD_CYCLES  = 1000,
    parameter int GAP_CYCLES   = 10,
    parameter int CNT_W        = 16,
    parameter int IDLE_TIMEOUT = 5000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] btn,
    output logic [N_REQ-1:0] btn_out,
    output logic [IDX_W-1:0] grant_id,
    output logic [N_REQ-1:0] pending,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [N_REQ-1:0] btn_q;
    logic [N_REQ-1:0] pending_q, pending_d;
    logic [N_REQ-1:0] btn_out_q, btn_out_d;
    logic [IDX_W-1:0] grant_id_q, grant_id_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [N_REQ-1:0] rise;
    logic [N_REQ-1:0] clr;
    logic [N_REQ-1:0] demo_set;
    logic             arb_valid;
    logic [IDX_W-1:0] arb_idx;
    logic             grant_now;

    assign rise = btn & ~btn_q;

    rr_arbiter8 u_arb (
        .req   (pending_q),
        .last  (last_q),
        .valid (arb_valid),
        .idx   (arb_idx)
    );

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        btn_out_d  = btn_out_q;
        grant_id_d = grant_id_q;
        last_d     = last_q;
        clr        = '0;
        grant_now  = 1'b0;

        case (state_q)
            IDLE: begin
                btn_out_d = '0;
                grant_now = arb_valid;
            end
            SHOW: begin
                timer_d = timer_q + 1'b1;
                if (timer_q == CNT_W'(HOLD_CYCLES - 1)) begin
                    timer_d   = '0;
                    btn_out_d = '0;
                    if (GAP_CYCLES == 0) begin
                        grant_now = arb_valid;
                        state_d   = IDLE;
                    end else begin
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                btn_out_d = '0;
                timer_d   = timer_q + 1'b1;
                if (timer_q == CNT_W'(GAP_CYCLES - 1)) begin
                    timer_d   = '0;
                    grant_now = arb_valid;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                timer_d   = '0;
                btn_out_d = '0;
            end
        endcase

        // A grant overrides whichever exit the state chose above.
        if (grant_now) begin
            state_d    = SHOW;
            timer_d    = '0;
            btn_out_d  = idx_to_onehot(arb_idx);
            grant_id_d = arb_idx;
            last_d     = arb_idx;
            clr        = idx_to_onehot(arb_idx);
        end

        // Set wins over clear, so a re-press of the bit being granted stays queued.
        pending_d = (pending_q & ~clr) | rise | demo_set;
    end

`ifdef LED_REQ_SEQ_DEMO_EN
    logic [CNT_W-1:0] idle_q, idle_d;
    logic [IDX_W-1:0] demo_ptr_q, demo_ptr_d;

    always_comb begin
        idle_d     = '0;
        demo_ptr_d = demo_ptr_q;
        demo_set   = '0;
        if (state_q == IDLE && pending_q == '0 && rise == '0) begin
            if (idle_q == CNT_W'(IDLE_TIMEOUT - 1)) begin
                demo_set   = idx_to_onehot(demo_ptr_q);
                demo_ptr_d = demo_ptr_q + 1'b1;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_q     <= '0;
            demo_ptr_q <= '0;
        end else begin
            idle_q     <= idle_d;
            demo_ptr_q <= demo_ptr_d;
        end
    end
`else
    logic unused_idle_timeout;
    assign unused_idle_timeout = (IDLE_TIMEOUT != 0);
    assign demo_set            = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            btn_q      <= '0;
            pending_q  <= '0;
            btn_out_q  <= '0;
            grant_id_q <= '0;
            last_q     <= IDX_W'(N_REQ - 1);
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            timer_q    <= timer_d;
            btn_q      <= btn;
            pending_q  <= pending_d;
            btn_out_q  <= btn_out_d;
            grant_id_q <= grant_id_d;
            last_q     <= last_d;
        end
    end

    assign btn_out  = btn_out_q;
    assign grant_id = grant_id_q;
    assign pending  = pending_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_led_request_sequencer.sv
// Directed bench for led_request_sequencer with a cycle-level reference model
// (down-counting show/gap windows plus a pending bit-set) checked every cycle.
module tb_led_request_sequencer;

    localparam int HOLD = 4;
    localparam int GAPC = 2;
    localparam int TOUT = 20;

    logic       clk;
    logic       rst;
    logic [7:0] btn;
    logic [7:0] btn_out;
    logic [2:0] grant_id;
    logic [7:0] pending;
    logic       busy;

    int total = 0;
    int bad   = 0;

    led_request_sequencer #(
        .HOLD_CYCLES  (HOLD),
        .GAP_CYCLES   (GAPC),
        .CNT_W        (16),
        .IDLE_TIMEOUT (TOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn      (btn),
        .btn_out  (btn_out),
        .grant_id (grant_id),
        .pending  (pending),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: remaining show/gap cycles, pending set, last winner.
    int         m_show, m_gap, m_idle;
    logic [7:0] m_pend, m_out, m_prev;
    logic [2:0] m_gid, m_last, m_dptr;
    logic       m_busy;

    function automatic int pick(input logic [7:0] p, input logic [2:0] last);
        for (int i = 1; i <= 8; i++) begin
            int j;
            j = (int'(last) + i) % 8;
            if (p[j]) return j;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_show = 0; m_gap = 0; m_idle = 0;
            m_pend = '0; m_out = '0; m_prev = '0;
            m_gid = '0; m_last = 3'd7; m_dptr = '0; m_busy = 1'b0;
        end else begin
            logic [7:0] rise, old_pend, clr, dset;
            logic       was_idle, try_grant;
            int         w;
            rise      = btn & ~m_prev;
            m_prev    = btn;
            old_pend  = m_pend;
            clr       = '0;
            dset      = '0;
            was_idle  = (m_show == 0 && m_gap == 0);
            try_grant = 1'b0;
            if (m_show > 0) begin
                m_show--;
                if (m_show == 0) begin
                    m_out = '0;
                    if (GAPC > 0) m_gap = GAPC;
                    else try_grant = 1'b1;
                end
            end else if (m_gap > 0) begin
                m_gap--;
                if (m_gap == 0) try_grant = 1'b1;
            end else begin
                try_grant = 1'b1;
            end
            if (try_grant && old_pend != 0) begin
                w      = pick(old_pend, m_last);
                m_out  = 8'b1 << w;
                m_gid  = 3'(w);
                m_last = 3'(w);
                m_show = HOLD;
                clr    = 8'b1 << w;
            end
`ifdef LED_REQ_SEQ_DEMO_EN
            if (was_idle && old_pend == 0 && rise == 0) begin
                if (m_idle == TOUT - 1) begin
                    dset   = 8'b1 << m_dptr;
                    m_dptr = m_dptr + 3'd1;
                    m_idle = 0;
                end else begin
                    m_idle++;
                end
            end else begin
                m_idle = 0;
            end
`else
            if (was_idle) m_idle = 0;
`endif
            m_pend = (old_pend & ~clr) | rise | dset;
            m_busy = (m_show > 0 || m_gap > 0);
        end
    end

    always @(negedge clk) begin
        check("cmp_btn_out", btn_out, m_out);
        check("cmp_grant_id", grant_id, m_gid);
        check("cmp_pending", pending, m_pend);
        check("cmp_busy", busy, m_busy);
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        btn = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    logic [7:0] exp_out  [8] = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00};
    logic       exp_busy [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        rst = 1'b0;
        btn = '0;

        // Reset held for 10 cycles, then released with no presses.
        repeat (10) begin
            @(negedge clk);
            check("rst_btn_out", btn_out, 8'h00);
            check("rst_pending", pending, 8'h00);
            check("rst_busy", busy, 1'b0);
        end
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_out", btn_out, 8'h00);

        // Single press held for 20 cycles: one 4-cycle grant, 2-cycle gap.
        btn = 8'h01;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("single_out", btn_out, exp_out[i]);
            check("single_busy", busy, exp_busy[i]);
        end
        repeat (12) begin
            @(negedge clk);
            check("single_no_regrant", btn_out, 8'h00);
        end
        btn = 8'h00;
        check("single_pending", pending, 8'h00);

        // Simultaneous press of bits 0 and 2.
        do_reset();
        btn = 8'h05;
        @(negedge clk);
        btn = 8'h00;
        check("simul_pending", pending, 8'h05);
        @(negedge clk);
        check("simul_first", btn_out, 8'h01);
        check("simul_first_id", grant_id, 3'd0);
        repeat (6) @(negedge clk);
        check("simul_second", btn_out, 8'h04);
        check("simul_second_id", grant_id, 3'd2);
        repeat (6) @(negedge clk);
        check("simul_idle", busy, 1'b0);
        check("simul_id_hold", grant_id, 3'd2);

        // Fairness: bits 0 and 3 queued while bit 1 is shown; 3 goes first.
        do_reset();
        btn = 8'h02;
        @(negedge clk);
        btn = 8'h00;
        @(negedge clk);
        check("fair_show1", btn_out, 8'h02);
        btn = 8'h09;
        @(negedge clk);
        btn = 8'h00;
        check("fair_pending", pending, 8'h09);
        repeat (5) @(negedge clk);
        check("fair_bit3", btn_out, 8'h08);
        check("fair_bit3_id", grant_id, 3'd3);
        repeat (6) @(negedge clk);
        check("fair_bit0", btn_out, 8'h01);

        // Re-press of the bit currently on display queues it again.
        do_reset();
        btn = 8'h01;
        @(negedge clk);
        btn = 8'h00;
        @(negedge clk);
        check("repress_show", btn_out, 8'h01);
        btn = 8'h01;
        @(negedge clk);
        btn = 8'h00;
        check("repress_pending", pending, 8'h01);
        repeat (5) @(negedge clk);
        check("repress_again", btn_out, 8'h01);
        check("repress_cleared", pending, 8'h00);

        // Asynchronous reset between edges during SHOW with a queued request.
        do_reset();
        btn = 8'h01;
        @(negedge clk);
        btn = 8'h00;
        @(negedge clk);
        btn = 8'h02;
        @(negedge clk);
        btn = 8'h00;
        check("areset_pre_pend", pending, 8'h02);
        check("areset_pre_out", btn_out, 8'h01);
        #2 rst = 1'b0;
        #1;
        check("areset_out", btn_out, 8'h00);
        check("areset_pending", pending, 8'h00);
        check("areset_busy", busy, 1'b0);

        // Button held across reset release counts as exactly one press.
        btn = 8'h10;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("held_pending", pending, 8'h10);
        @(negedge clk);
        check("held_out", btn_out, 8'h10);
        check("held_id", grant_id, 3'd4);
        repeat (10) @(negedge clk);
        check("held_once_out", btn_out, 8'h00);
        check("held_once_pend", pending, 8'h00);
        btn = 8'h00;

`ifdef LED_REQ_SEQ_DEMO_EN
        // Demo mode: synthetic grants walk 0x01, 0x02, 0x04 with no presses.
        begin
            logic [7:0] seen [3];
            int         n;
            logic [7:0] prev;
            do_reset();
            n    = 0;
            prev = 8'h00;
            for (int c = 0; c < 300 && n < 3; c++) begin
                @(negedge clk);
                if (btn_out != 8'h00 && prev == 8'h00) begin
                    seen[n] = btn_out;
                    n++;
                end
                prev = btn_out;
            end
            check("demo_count", n, 3);
            if (n == 3) begin
                check("demo_g0", seen[0], 8'h01);
                check("demo_g1", seen[1], 8'h02);
                check("demo_g2", seen[2], 8'h04);
            end
        end
`else
        // Without demo mode the block stays idle indefinitely.
        repeat (40) @(negedge clk);
        check("idle_forever_busy", busy, 1'b0);
        check("idle_forever_out", btn_out, 8'h00);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
